multicycle_control_fsm: RTL and testbench



---
 rtl/multicycle_control_fsm.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32I core: sequences memory, ALU and
// PC/IR/register-file enables, counts retired instructions and flags bad opcodes.
module multicycle_control_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ImmSrc,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StAluWb    = 4'd7,
      StExecI    = 4'd8,
      StJal      = 4'd9,
      StBeq      = 4'd10
   } state_e;

   localparam logic [6:0] OpLw   = 7'b0000011;
   localparam logic [6:0] OpSw   = 7'b0100011;
   localparam logic [6:0] OpR    = 7'b0110011;
   localparam logic [6:0] OpI    = 7'b0010011;
   localparam logic [6:0] OpBeq  = 7'b1100011;
   localparam logic [6:0] OpJal  = 7'b1101111;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;

   logic pc_update, branch, ir_write, mem_write, reg_write, retire;

   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      retire    = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;

      case (state_q)
         StFetch: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_write  = mem_ready;
            pc_update = mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OpLw, OpSw: state_d = StMemAdr;
               OpR:        state_d = StExecR;
               OpI:        state_d = StExecI;
               OpJal:      state_d = StJal;
               OpBeq:      state_d = StBeq;
               default: begin
                  state_d   = StFetch;
                  illegal_d = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == OpSw) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
            state_d   = StFetch;
            retire    = 1'b1;
         end
         StMemWrite: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               state_d = StFetch;
               retire  = 1'b1;
            end
         end
         StExecR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = StAluWb;
         end
         StExecI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
            retire    = 1'b1;
         end
         StJal: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = StAluWb;
         end
         StBeq: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
            state_d = StFetch;
            retire  = 1'b1;
         end
         default: state_d = StFetch;
      endcase

      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_comb begin
      case (op)
         OpSw:    ImmSrc = 2'b01;
         OpBeq:   ImmSrc = 2'b10;
         OpJal:   ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Architectural write enables are suppressed for the whole reset window.
   assign PCWrite     = (pc_update | (branch & Zero)) & ~rst;
   assign IRWrite     = ir_write & ~rst;
   assign MemWrite    = mem_write & ~rst;
   assign RegWrite    = reg_write & ~rst;
   assign state       = state_q;
   assign illegal_op  = illegal_q;
   assign instr_count = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; a 4-bit counter keeps the wrap test short.
module tb_multicycle_control_fsm;

   localparam int unsigned CntW = 4;

   localparam logic [6:0] OpLw  = 7'b0000011;
   localparam logic [6:0] OpSw  = 7'b0100011;
   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpBeq = 7'b1100011;
   localparam logic [6:0] OpJal = 7'b1101111;
   localparam logic [6:0] OpBad = 7'b1111111;

   logic            clk, rst, Zero, mem_ready;
   logic [6:0]      op;
   logic            PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
   logic [1:0]      ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic [3:0]      state;
   logic [CntW-1:0] instr_count;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_control_fsm #(.CNT_W(CntW)) dut (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .Zero        (Zero),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .AdrSrc      (AdrSrc),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .RegWrite    (RegWrite),
      .ResultSrc   (ResultSrc),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .ImmSrc      (ImmSrc),
      .state       (state),
      .illegal_op  (illegal_op),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      op        = OpR;
      mem_ready = 1'b1;
      Zero      = 1'b0;
      repeat (2) tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_irwrite", 32'(IRWrite), 32'd0);
      check("rst_pcwrite", 32'(PCWrite), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_illegal", 32'(illegal_op), 32'd0);
      rst = 1'b0;
      #1;

      // R-type: 0,1,6,7,0
      check("r_fetch_state", 32'(state), 32'd0);
      check("r_fetch_irwrite", 32'(IRWrite), 32'd1);
      check("r_fetch_pcwrite", 32'(PCWrite), 32'd1);
      check("r_fetch_srcb", 32'(ALUSrcB), 32'd2);
      check("r_fetch_result", 32'(ResultSrc), 32'd2);
      tick();
      check("r_decode_state", 32'(state), 32'd1);
      check("r_decode_srca", 32'(ALUSrcA), 32'd1);
      check("r_decode_regw", 32'(RegWrite), 32'd0);
      tick();
      check("r_exec_state", 32'(state), 32'd6);
      check("r_exec_aluop", 32'(ALUOp), 32'd2);
      check("r_exec_regw", 32'(RegWrite), 32'd0);
      tick();
      check("r_wb_state", 32'(state), 32'd7);
      check("r_wb_regw", 32'(RegWrite), 32'd1);
      check("r_wb_result", 32'(ResultSrc), 32'd0);
      tick();
      check("r_done_state", 32'(state), 32'd0);
      check("r_done_count", 32'(instr_count), 32'd1);

      // lw with three wait cycles in MEMREAD: 8 cycles total
      op = OpLw;
      #1;
      check("lw_immsrc", 32'(ImmSrc), 32'd0);
      tick();
      check("lw_decode_state", 32'(state), 32'd1);
      tick();
      check("lw_memadr_state", 32'(state), 32'd2);
      check("lw_memadr_srca", 32'(ALUSrcA), 32'd2);
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("lw_wait%0d_state", i), 32'(state), 32'd3);
         check($sformatf("lw_wait%0d_adrsrc", i), 32'(AdrSrc), 32'd1);
         tick();
      end
      check("lw_last_read_state", 32'(state), 32'd3);
      mem_ready = 1'b1;
      tick();
      check("lw_wb_state", 32'(state), 32'd4);
      check("lw_wb_result", 32'(ResultSrc), 32'd1);
      check("lw_wb_regw", 32'(RegWrite), 32'd1);
      tick();
      check("lw_done_state", 32'(state), 32'd0);
      check("lw_done_count", 32'(instr_count), 32'd2);

      // beq taken then not taken
      op   = OpBeq;
      Zero = 1'b1;
      repeat (2) tick();
      check("beq1_state", 32'(state), 32'd10);
      check("beq1_pcwrite", 32'(PCWrite), 32'd1);
      check("beq1_aluop", 32'(ALUOp), 32'd1);
      check("beq1_immsrc", 32'(ImmSrc), 32'd2);
      tick();
      check("beq1_done_state", 32'(state), 32'd0);
      check("beq1_done_count", 32'(instr_count), 32'd3);
      Zero = 1'b0;
      repeat (2) tick();
      check("beq2_state", 32'(state), 32'd10);
      check("beq2_pcwrite", 32'(PCWrite), 32'd0);
      check("beq2_aluop", 32'(ALUOp), 32'd1);
      check("beq2_immsrc", 32'(ImmSrc), 32'd2);
      tick();
      check("beq2_done_count", 32'(instr_count), 32'd4);

      // sw: 0,1,2,5,0
      op = OpSw;
      #1;
      check("sw_immsrc", 32'(ImmSrc), 32'd1);
      check("sw_fetch_memw", 32'(MemWrite), 32'd0);
      tick();
      check("sw_decode_state", 32'(state), 32'd1);
      tick();
      check("sw_memadr_state", 32'(state), 32'd2);
      check("sw_memadr_memw", 32'(MemWrite), 32'd0);
      check("sw_memadr_adrsrc", 32'(AdrSrc), 32'd0);
      tick();
      check("sw_write_state", 32'(state), 32'd5);
      check("sw_write_memw", 32'(MemWrite), 32'd1);
      check("sw_write_adrsrc", 32'(AdrSrc), 32'd1);
      tick();
      check("sw_done_state", 32'(state), 32'd0);
      check("sw_done_memw", 32'(MemWrite), 32'd0);
      check("sw_done_count", 32'(instr_count), 32'd5);

      // Illegal opcode: 2 cycles, one-cycle pulse, not counted
      op = OpBad;
      tick();
      check("bad_decode_state", 32'(state), 32'd1);
      check("bad_decode_flag", 32'(illegal_op), 32'd0);
      tick();
      check("bad_back_state", 32'(state), 32'd0);
      check("bad_pulse", 32'(illegal_op), 32'd1);
      check("bad_count", 32'(instr_count), 32'd5);
      tick();
      check("bad_pulse_end", 32'(illegal_op), 32'd0);
      check("bad_redecode_state", 32'(state), 32'd1);

      // Reset during a stalled MEMWRITE abandons the store
      op = OpSw;
      tick();
      check("rsw_memadr_state", 32'(state), 32'd2);
      mem_ready = 1'b0;
      tick();
      tick();
      check("rsw_hold_state", 32'(state), 32'd5);
      check("rsw_hold_memw", 32'(MemWrite), 32'd1);
      rst = 1'b1;
      #1;
      check("rsw_rst_memw", 32'(MemWrite), 32'd0);
      tick();
      check("rsw_after_state", 32'(state), 32'd0);
      check("rsw_after_count", 32'(instr_count), 32'd0);
      check("rsw_after_memw", 32'(MemWrite), 32'd0);
      rst       = 1'b0;
      mem_ready = 1'b1;

      // Fill the counter to all-ones with R-types, then wrap it with a jal
      op = OpR;
      for (int i = 1; i <= 15; i++) begin
         repeat (4) tick();
         check($sformatf("fill%0d_state", i), 32'(state), 32'd0);
         check($sformatf("fill%0d_count", i), 32'(instr_count), 32'(i));
      end
      op = OpJal;
      repeat (2) tick();
      check("jal_state", 32'(state), 32'd9);
      check("jal_pcwrite", 32'(PCWrite), 32'd1);
      check("jal_immsrc", 32'(ImmSrc), 32'd3);
      check("jal_srca", 32'(ALUSrcA), 32'd1);
      tick();
      check("jal_wb_state", 32'(state), 32'd7);
      check("jal_wb_regw", 32'(RegWrite), 32'd1);
      tick();
      check("jal_done_state", 32'(state), 32'd0);
      check("jal_wrap_count", 32'(instr_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
